day08_pair_streamer: RTL and testbench
======================================

Name: day08_pair_streamer

Overview:
- Producer side of the day08 batch interface: holds the point list and streams every unordered pair (i<j) to the distance/sort/union-find top level, as reference-line batches of BATCH_SIZE candidate points.
- Sits between the input parser, which writes points, and the day08 top, which consumes batches.
- Drives batch_coords/batch_indices/batch_valid/batch_line_end/batch_stream_end and obeys the consumer's in_ready.

Parameters:
- MAX_NODE_COUNT, 2000, point memory depth; INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT).
- COORD_BIT_WIDTH, 12, bits per coordinate.
- DIMENSIONS, 3, coordinates per point.
- BATCH_SIZE, 16, points per batch; ROWS = ceil(MAX_NODE_COUNT/BATCH_SIZE).

Ports:
- clk  in  1  clock (single clock domain)
- rst_n  in  1  asynchronous active-low reset
- point_wr_en  in  1  write one point (honoured in IDLE only)
- point_wr_addr  in  INDEX_BIT_WIDTH  point index
- point_wr_coords  in  [DIMENSIONS][COORD_BIT_WIDTH]  coordinates
- node_count  in  INDEX_BIT_WIDTH+1  number of points N, sampled at start
- start  in  1  begin streaming (IDLE only)
- busy  out  1  high from accepted start until final batch transfers
- done  out  1  one-cycle pulse after final batch transfer
- out_ready  in  1  consumer in_ready
- batch_coords  out  [BATCH_SIZE][DIMENSIONS][COORD_BIT_WIDTH]  slot coordinates
- batch_indices  out  [BATCH_SIZE][INDEX_BIT_WIDTH]  slot point indices
- batch_valid  out  BATCH_SIZE  per-slot valid; the batch is presented when nonzero
- batch_line_end  out  1  last batch of the current reference line
- batch_stream_end  out  1  final batch of the stream, gated by out_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, batch_valid, batch_line_end and batch_stream_end are 0; batch_coords and batch_indices are 0; counters are 0. Point memory is not cleared.
- Transfer: occurs on a clock edge with |batch_valid && out_ready. While out_ready=0, all batch_* outputs hold stable. All outputs are registered except batch_stream_end.
- batch_stream_end equals final_reg && out_ready. The consumer registers this signal every cycle, so it must only be high in the final transfer cycle.
- FSM states: IDLE, HEADER, ROWS, FLUSH.
  - IDLE: start=1 latches Nc = min(node_count, MAX_NODE_COUNT) and sets i=0. If Nc<2, go to FLUSH. Otherwise go to HEADER. busy rises on the next edge. The first batch is valid 1 cycle after start.
  - HEADER: presents slot0 = point i (index i) with batch_valid = only bit0 set, line_end=0. The consumer latches slot0 as the reference; u==v drops that pair. On transfer, set r = (i+1)/BATCH_SIZE and go to ROWS.
  - ROWS: presents memory row r. Slot k = point r*B+k. valid[k] = (r*B+k > i) && (r*B+k < Nc). line_end = (r == (Nc-1)/B). On transfer:
    - if this is not the line's last row, r++;
    - else if i == Nc-2, the stream is done: go to IDLE, pulse done, drop busy;
    - else i++ and go to HEADER.
  - FLUSH (Nc<2): presents a single batch with slot0 = index 0 and line_end=1; stream_end follows the gating rule. On transfer, go to IDLE and pulse done.
- Invalid slots drive index 0 and coords 0.
- start while busy is ignored. point_wr_en while busy is ignored and memory is unchanged.
- Simultaneous point_wr_en and start in IDLE: the write is committed first, and streaming sees the new value.
- Reset mid-stream: outputs drop immediately with no partial line_end/stream_end. The next start restarts at i=0.
- Total transfers for Nc>=2: sum over i=0..Nc-2 of [1 + ((Nc-1)/B − (i+1)/B + 1)].

Decomposition:
- day08_pkg: INDEX_BIT_WIDTH, coord_t, point_t (packed [DIMENSIONS] coord_t), state enum, and the ROWS constant. These are shared with day08_top and the parser.
- Sub-module point_row_ram: ROWS x BATCH_SIZE points, per-slot write enable, asynchronous full-row read. It is used for both the header read (row i/B, slot i%B) and the row read. Its contents are not reset.

Test Plan:
- N=5, B=4, points written with coords = index: expect 11 transfers. Line0: H{0}, row0 slots1-3 {1,2,3}, row1 slot0 {4} with line_end. Line1: H{1}, {2,3}, {4} line_end. Line2: H{2}, {3}, {4} line_end. Line3: H{3}, {4} with line_end + stream_end. Then done pulses once.
- Same stream with out_ready toggled in a pseudo-random pattern (50% duty): identical transfer sequence, outputs stable while stalled, stream_end never high without out_ready.
- N=1 and N=0: exactly one batch, slot0 index 0, valid=0001, line_end and stream_end high, done pulses; never more than one transfer.
- N=8, B=4 (row-aligned boundary): line6 emits H{6} then row1 with valid only slot3 {7}, line_end + stream_end; no empty rows are emitted.
- Assert rst_n=0 during line 2 while stalled: busy=0 and batch_valid=0 immediately. After release, start with N=5 reproduces the first scenario, proving memory is retained.
- point_wr_en and start pulsed while busy: no effect on memory or stream order. A write in the same cycle as start in IDLE is visible in the stream.

Source files
------------

// File: rtl/day08_pkg.sv
// Shared day08 definitions: default sizing, point types and the pair-streamer state encoding.
package day08_pkg;

  localparam int MAX_NODE_COUNT  = 2000;
  localparam int COORD_BIT_WIDTH = 12;
  localparam int DIMENSIONS      = 3;
  localparam int BATCH_SIZE      = 16;
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);
  localparam int ROWS            = (MAX_NODE_COUNT + BATCH_SIZE - 1) / BATCH_SIZE;

  typedef logic [COORD_BIT_WIDTH-1:0] coord_t;
  typedef coord_t [DIMENSIONS-1:0]    point_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_ROWS,
    S_FLUSH
  } state_e;

  // Address width for a table of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/day08_pair_streamer_point_row_ram.sv
// Point store organised as rows of BATCH_SIZE points: per-slot write, asynchronous whole-row read.
module point_row_ram import day08_pkg::*; #(
  parameter int  NUM_ROWS    = ROWS,
  parameter int  NUM_SLOTS   = BATCH_SIZE,
  parameter int  POINT_WIDTH = DIMENSIONS * COORD_BIT_WIDTH,
  localparam int ROW_W       = clog2_min1(NUM_ROWS),
  localparam int SLOT_W      = clog2_min1(NUM_SLOTS)
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [ROW_W-1:0]                      wr_row,
  input  logic [SLOT_W-1:0]                     wr_slot,
  input  logic [POINT_WIDTH-1:0]                wr_data,
  input  logic [ROW_W-1:0]                      rd_row,
  output logic [NUM_SLOTS-1:0][POINT_WIDTH-1:0] rd_data
);

  logic [NUM_SLOTS-1:0][POINT_WIDTH-1:0] mem_q [NUM_ROWS];

  // NOTE: storage arrays get no reset; clearing them would cost a write port per
  // cycle and the contents are only meaningful once the parser has written them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_row][wr_slot] <= wr_data;
  end

  assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/day08_pair_streamer.sv
// Streams every unordered point pair (i<j) as a header batch {i} followed by the memory rows holding j>i.
module day08_pair_streamer #(
  parameter int  MAX_NODE_COUNT  = 2000,
  parameter int  COORD_BIT_WIDTH = 12,
  parameter int  DIMENSIONS      = 3,
  parameter int  BATCH_SIZE      = 16,
  localparam int IDX_W           = $clog2(MAX_NODE_COUNT)
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic                                                        point_wr_en,
  input  logic [IDX_W-1:0]                                            point_wr_addr,
  input  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  point_wr_coords,
  input  logic [IDX_W:0]                                              node_count,
  input  logic                                                        start,
  output logic                                                        busy,
  output logic                                                        done,
  input  logic                                                        out_ready,
  output logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] batch_coords,
  output logic [BATCH_SIZE-1:0][IDX_W-1:0]                            batch_indices,
  output logic [BATCH_SIZE-1:0]                                       batch_valid,
  output logic                                                        batch_line_end,
  output logic                                                        batch_stream_end
);
  import day08_pkg::*;

  localparam int N_ROWS = (MAX_NODE_COUNT + BATCH_SIZE - 1) / BATCH_SIZE;
  localparam int ROW_W  = clog2_min1(N_ROWS);
  localparam int SLOT_W = clog2_min1(BATCH_SIZE);

  typedef logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] pt_t;
  typedef pt_t [BATCH_SIZE-1:0]                        row_t;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     i_q, i_d;
  logic [ROW_W-1:0]                     r_q, r_d;
  logic [IDX_W:0]                       nc_q, nc_d;
  logic                                 busy_q, busy_d, done_q, done_d, load;
  row_t                                 coords_q, coords_d;
  logic [BATCH_SIZE-1:0][IDX_W-1:0]     indices_q, indices_d;
  logic [BATCH_SIZE-1:0]                valid_q, valid_d;
  logic                                 line_end_q, line_end_d, final_q, final_d;

  logic                                 wr_accept, xfer;
  logic [ROW_W-1:0]                     wr_row, rd_row;
  logic [SLOT_W-1:0]                    wr_slot;
  row_t                                 rd_data, row_fwd;

  assign wr_accept = point_wr_en && (state_q == S_IDLE) && (int'(point_wr_addr) < MAX_NODE_COUNT);
  assign wr_row    = ROW_W'(int'(point_wr_addr) / BATCH_SIZE);
  assign wr_slot   = SLOT_W'(int'(point_wr_addr) % BATCH_SIZE);
  assign xfer      = (|valid_q) && out_ready;
  // The next batch is read from the row it will present: row r in ROWS, otherwise the row holding point i.
  assign rd_row    = (state_d == S_ROWS) ? r_d : ROW_W'(int'(i_d) / BATCH_SIZE);

  point_row_ram #(
    .NUM_ROWS    (N_ROWS),
    .NUM_SLOTS   (BATCH_SIZE),
    .POINT_WIDTH (DIMENSIONS * COORD_BIT_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_row  (wr_row),
    .wr_slot (wr_slot),
    .wr_data (point_wr_coords),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    int nc_in;
    state_d = state_q;
    i_d     = i_q;
    r_d     = r_q;
    nc_d    = nc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    nc_in   = (int'(node_count) > MAX_NODE_COUNT) ? MAX_NODE_COUNT : int'(node_count);
    unique case (state_q)
      S_IDLE: if (start) begin
        nc_d    = (IDX_W+1)'(nc_in);
        i_d     = '0;
        r_d     = '0;
        busy_d  = 1'b1;
        load    = 1'b1;
        state_d = (nc_in < 2) ? S_FLUSH : S_HEADER;
      end
      S_HEADER: if (xfer) begin
        r_d     = ROW_W'((int'(i_q) + 1) / BATCH_SIZE);
        load    = 1'b1;
        state_d = S_ROWS;
      end
      S_ROWS: if (xfer) begin
        load = 1'b1;
        if (int'(r_q) != (int'(nc_q) - 1) / BATCH_SIZE) begin
          r_d = r_q + 1'b1;
        end else if (int'(i_q) == int'(nc_q) - 2) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_HEADER;
        end
      end
      S_FLUSH: if (xfer) begin
        load    = 1'b1;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Builds the batch for the state being entered; an IDLE write to the same row is forwarded so start sees it.
  always_comb begin
    int pidx;
    pidx       = 0;
    row_fwd    = rd_data;
    if (wr_accept && (wr_row == rd_row)) row_fwd[wr_slot] = point_wr_coords;
    coords_d   = '0;
    indices_d  = '0;
    valid_d    = '0;
    line_end_d = 1'b0;
    final_d    = 1'b0;
    unique case (state_d)
      S_HEADER, S_FLUSH: begin
        valid_d[0]   = 1'b1;
        indices_d[0] = i_d;
        coords_d[0]  = row_fwd[SLOT_W'(int'(i_d) % BATCH_SIZE)];
        line_end_d   = (state_d == S_FLUSH);
        final_d      = (state_d == S_FLUSH);
      end
      S_ROWS: begin
        line_end_d = (int'(r_d) == (int'(nc_d) - 1) / BATCH_SIZE);
        final_d    = line_end_d && (int'(i_d) == int'(nc_d) - 2);
        for (int k = 0; k < BATCH_SIZE; k++) begin
          pidx = int'(r_d) * BATCH_SIZE + k;
          if ((pidx > int'(i_d)) && (pidx < int'(nc_d))) begin
            valid_d[SLOT_W'(k)]   = 1'b1;
            indices_d[SLOT_W'(k)] = IDX_W'(pidx);
            coords_d[SLOT_W'(k)]  = row_fwd[SLOT_W'(k)];
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      r_q        <= '0;
      nc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coords_q   <= '0;
      indices_q  <= '0;
      valid_q    <= '0;
      line_end_q <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      r_q     <= r_d;
      nc_q    <= nc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        coords_q   <= coords_d;
        indices_q  <= indices_d;
        valid_q    <= valid_d;
        line_end_q <= line_end_d;
        final_q    <= final_d;
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign batch_coords     = coords_q;
  assign batch_indices    = indices_q;
  assign batch_valid      = valid_q;
  assign batch_line_end   = line_end_q;
  // The consumer samples this every cycle, so it may only be high on the edge that transfers the last batch.
  assign batch_stream_end = final_q && out_ready;

endmodule

// File: tb/tb_day08_pair_streamer.sv
// Directed bench for day08_pair_streamer with hand-written transfer tables (B=4, 16-point memory).
module tb_day08_pair_streamer;

  localparam int MAXN = 16;
  localparam int CW   = 12;
  localparam int DIM  = 3;
  localparam int B    = 4;
  localparam int IW   = 4;

  typedef logic [DIM-1:0][CW-1:0] pt_t;
  typedef struct {
    logic [B-1:0] mask;
    int           base;
    bit           le;
    bit           se;
  } xfer_t;

  logic                   clk;
  logic                   rst_n;
  logic                   point_wr_en;
  logic [IW-1:0]          point_wr_addr;
  pt_t                    point_wr_coords;
  logic [IW:0]            node_count;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   out_ready;
  logic [B-1:0][DIM-1:0][CW-1:0] batch_coords;
  logic [B-1:0][IW-1:0]   batch_indices;
  logic [B-1:0]           batch_valid;
  logic                   batch_line_end;
  logic                   batch_stream_end;

  int    n_cmp  = 0;
  int    n_fail = 0;
  pt_t   exp_mem [MAXN];
  xfer_t exp_q[$];

  day08_pair_streamer #(
    .MAX_NODE_COUNT  (MAXN),
    .COORD_BIT_WIDTH (CW),
    .DIMENSIONS      (DIM),
    .BATCH_SIZE      (B)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .point_wr_en      (point_wr_en),
    .point_wr_addr    (point_wr_addr),
    .point_wr_coords  (point_wr_coords),
    .node_count       (node_count),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .out_ready        (out_ready),
    .batch_coords     (batch_coords),
    .batch_indices    (batch_indices),
    .batch_valid      (batch_valid),
    .batch_line_end   (batch_line_end),
    .batch_stream_end (batch_stream_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pt_t make_pt(input int p);
    pt_t v;
    for (int d = 0; d < DIM; d++) v[d] = CW'(12'h100 + p * 8 + d + 1);
    return v;
  endfunction

  task automatic push(input logic [B-1:0] m, input int base, input bit le, input bit se);
    xfer_t x;
    x.mask = m; x.base = base; x.le = le; x.se = se;
    exp_q.push_back(x);
  endtask

  // N=5: lines 0..3, hand-derived.
  task automatic push_n5();
    push(4'b0001, 0, 0, 0); push(4'b1110, 0, 0, 0); push(4'b0001, 4, 1, 0);
    push(4'b0001, 1, 0, 0); push(4'b1100, 0, 0, 0); push(4'b0001, 4, 1, 0);
    push(4'b0001, 2, 0, 0); push(4'b1000, 0, 0, 0); push(4'b0001, 4, 1, 0);
    push(4'b0001, 3, 0, 0); push(4'b0001, 4, 1, 1);
  endtask

  task automatic write_pt(input int p, input pt_t v);
    @(negedge clk);
    point_wr_en = 1'b1; point_wr_addr = IW'(p); point_wr_coords = v;
    @(negedge clk);
    point_wr_en = 1'b0;
    exp_mem[p] = v;
  endtask

  task automatic start_stream(input string tag, input int n);
    @(negedge clk);
    node_count = (IW+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " busy after start"}, 160'(busy), 160'(1'b1));
    check({tag, " first batch valid"}, 160'(|batch_valid), 160'(1'b1));
  endtask

  // Consumes exp_q transfer by transfer; entered at the negedge following the start edge.
  task automatic run_stream(input string tag, input bit stall, input bit poke, input bit expect_done);
    int cyc = 0;
    int nx  = 0;
    bit prev_stall = 1'b0;
    logic [B-1:0][DIM-1:0][CW-1:0] snap_c, ec;
    logic [B-1:0][IW-1:0]          snap_i, ei;
    logic [B-1:0]                  snap_v;
    logic                          snap_le;
    xfer_t x;
    while (exp_q.size() > 0 && cyc < 400) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cyc == 3) begin
        point_wr_en = 1'b1; point_wr_addr = 4'd2; point_wr_coords = '1;
        start = 1'b1; node_count = 5'd8;
      end else if (poke && cyc == 4) begin
        point_wr_en = 1'b0; start = 1'b0;
      end
      #1;
      if (prev_stall)
        check($sformatf("%s hold@%0d", tag, cyc),
              {batch_coords, batch_indices, batch_valid, batch_line_end},
              {snap_c, snap_i, snap_v, snap_le});
      if (!out_ready)
        check($sformatf("%s stream_end gated@%0d", tag, cyc), 160'(batch_stream_end), 160'(1'b0));
      if ((|batch_valid) && out_ready) begin
        x  = exp_q.pop_front();
        ec = '0;
        ei = '0;
        for (int k = 0; k < B; k++)
          if (x.mask[k]) begin
            ec[k] = exp_mem[x.base + k];
            ei[k] = IW'(x.base + k);
          end
        check($sformatf("%s x%0d valid", tag, nx),   160'(batch_valid),      160'(x.mask));
        check($sformatf("%s x%0d indices", tag, nx), 160'(batch_indices),    160'(ei));
        check($sformatf("%s x%0d coords", tag, nx),  160'(batch_coords),     160'(ec));
        check($sformatf("%s x%0d line_end", tag, nx), 160'(batch_line_end),  160'(x.le));
        check($sformatf("%s x%0d stream_end", tag, nx), 160'(batch_stream_end), 160'(x.se));
        nx++;
      end
      prev_stall = (|batch_valid) && !out_ready;
      snap_c = batch_coords; snap_i = batch_indices; snap_v = batch_valid; snap_le = batch_line_end;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, " transfers outstanding at budget"}, 160'(exp_q.size()), 160'(0));
    exp_q.delete();
    if (expect_done) begin
      #1;
      check({tag, " done pulse"},        160'(done),        160'(1'b1));
      check({tag, " busy dropped"},      160'(busy),        160'(1'b0));
      check({tag, " valid after end"},   160'(batch_valid), 160'(0));
      check({tag, " stream_end after"},  160'(batch_stream_end), 160'(1'b0));
      @(negedge clk);
      #1;
      check({tag, " done single cycle"}, 160'(done),        160'(1'b0));
      check({tag, " no extra batch"},    160'(batch_valid), 160'(0));
    end
  endtask

  initial begin
    point_wr_en = 1'b0; point_wr_addr = '0; point_wr_coords = '0;
    node_count = '0; start = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",       160'(busy),             160'(0));
    check("reset done",       160'(done),             160'(0));
    check("reset valid",      160'(batch_valid),      160'(0));
    check("reset line_end",   160'(batch_line_end),   160'(0));
    check("reset stream_end", 160'(batch_stream_end), 160'(0));
    check("reset coords",     160'(batch_coords),     160'(0));
    check("reset indices",    160'(batch_indices),    160'(0));
    @(negedge clk) rst_n = 1'b1;

    for (int p = 0; p < MAXN; p++) write_pt(p, make_pt(p));

    push_n5();
    start_stream("n5", 5);
    run_stream("n5", 1'b0, 1'b0, 1'b1);

    push_n5();
    start_stream("n5 stall", 5);
    run_stream("n5 stall", 1'b1, 1'b0, 1'b1);

    push(4'b0001, 0, 1, 1);
    start_stream("n1", 1);
    run_stream("n1", 1'b1, 1'b0, 1'b1);

    push(4'b0001, 0, 1, 1);
    start_stream("n0", 0);
    run_stream("n0", 1'b0, 1'b0, 1'b1);

    push(4'b0001, 0, 0, 0); push(4'b1110, 0, 0, 0); push(4'b1111, 4, 1, 0);
    push(4'b0001, 1, 0, 0); push(4'b1100, 0, 0, 0); push(4'b1111, 4, 1, 0);
    push(4'b0001, 2, 0, 0); push(4'b1000, 0, 0, 0); push(4'b1111, 4, 1, 0);
    push(4'b0001, 3, 0, 0); push(4'b1111, 4, 1, 0);
    push(4'b0001, 4, 0, 0); push(4'b1110, 4, 1, 0);
    push(4'b0001, 5, 0, 0); push(4'b1100, 4, 1, 0);
    push(4'b0001, 6, 0, 0); push(4'b1000, 4, 1, 1);
    start_stream("n8", 8);
    run_stream("n8", 1'b0, 1'b0, 1'b1);

    push_n5();
    start_stream("busy poke", 5);
    run_stream("busy poke", 1'b0, 1'b1, 1'b1);

    // Stop partway: lines 0 and 1 only, then reset while line 2's header is stalled.
    push_n5();
    repeat (5) void'(exp_q.pop_back());
    start_stream("pre-reset", 5);
    run_stream("pre-reset", 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy",       160'(busy),             160'(0));
    check("midreset valid",      160'(batch_valid),      160'(0));
    check("midreset line_end",   160'(batch_line_end),   160'(0));
    check("midreset stream_end", 160'(batch_stream_end), 160'(0));
    check("midreset done",       160'(done),             160'(0));
    @(negedge clk) rst_n = 1'b1;
    push_n5();
    start_stream("post-reset", 5);
    run_stream("post-reset", 1'b0, 1'b0, 1'b1);

    // Write point 0 in the same cycle as start; the header must already carry the new value.
    @(negedge clk);
    point_wr_en = 1'b1; point_wr_addr = 4'd0; point_wr_coords = {12'h0AB, 12'h0CD, 12'h0EF};
    node_count = 5'd2; start = 1'b1;
    exp_mem[0] = {12'h0AB, 12'h0CD, 12'h0EF};
    @(negedge clk);
    point_wr_en = 1'b0; start = 1'b0;
    #1;
    check("wr+start busy", 160'(busy), 160'(1'b1));
    push(4'b0001, 0, 0, 0); push(4'b0010, 0, 1, 1);
    run_stream("wr+start", 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
